// File: rtl/fifo.sv
// Synchronous FIFO, 2**AWIDTH x DWIDTH, registered read data and occupancy-based flags.
// Optional FIFO_ERR_FLAG_EN adds err_o, a one-cycle pulse after a rejected request.
module fifo #(
   parameter int AWIDTH = 2,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              re_i,
`ifdef FIFO_ERR_FLAG_EN
   output logic              err_o,
`endif
   output logic [DWIDTH-1:0] data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              one_available_o,
   output logic              two_available_o
);

   localparam int DEPTH = 2 ** AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic [AWIDTH:0]   count;
   logic              wr_ok;
   logic              rd_ok;

   // Acceptance is judged against the flags as they stand before the edge,
   // so a read never frees room for a same-cycle write and vice versa.
   assign wr_ok = we_i & ~full_o;
   assign rd_ok = re_i & ~empty_o;

   // Status flags decode straight from the registered occupancy.
   assign empty_o         = (count == '0);
   assign full_o          = count[AWIDTH];
   assign one_available_o = (count != '0);
   assign two_available_o = (count >= (AWIDTH+1)'(2));

   // Storage array; contents are left alone by reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem[wr_ptr] <= data_i;
      end
   end

   // Write pointer advances on each accepted write, wrapping modulo depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
      end else if (wr_ok) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read pointer and registered output word advance on each accepted read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         data_o <= '0;
      end else if (rd_ok) begin
         rd_ptr <= rd_ptr + 1'b1;
         data_o <= mem[rd_ptr];
      end
   end

   // Occupancy tracks write-only (+1) and read-only (-1) cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         unique case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   // Error pulse registers any request refused because of full or empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_o <= 1'b0;
      end else begin
         err_o <= (we_i & full_o) | (re_i & empty_o);
      end
   end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed testbench for fifo at default parameters (depth 4, 8-bit data).
// Expected values are hand-computed constants per vector.
module tb_fifo;

   logic       clk;
   logic       reset;
   logic       we_i;
   logic [7:0] data_i;
   logic       re_i;
   logic [7:0] data_o;
   logic       empty_o;
   logic       full_o;
   logic       one_available_o;
   logic       two_available_o;
`ifdef FIFO_ERR_FLAG_EN
   logic       err_o;
`endif

   int vectors;
   int miscompares;

   fifo #(.AWIDTH(2), .DWIDTH(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .we_i            (we_i),
      .data_i          (data_i),
      .re_i            (re_i),
`ifdef FIFO_ERR_FLAG_EN
      .err_o           (err_o),
`endif
      .data_o          (data_o),
      .empty_o         (empty_o),
      .full_o          (full_o),
      .one_available_o (one_available_o),
      .two_available_o (two_available_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after posedge.
   task automatic step(input logic rst, input logic we, input logic [7:0] d,
                       input logic re);
      @(negedge clk);
      reset  = rst;
      we_i   = we;
      data_i = d;
      re_i   = re;
      @(posedge clk);
      #1;
      reset = 1'b0;
      we_i  = 1'b0;
      re_i  = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      step(1'b0, 1'b1, d, 1'b0);
   endtask

   task automatic rd();
      step(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   function automatic logic [2:0] ot();
      return {one_available_o, two_available_o, full_o};
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset  = 1'b0;
      we_i   = 1'b0;
      re_i   = 1'b0;
      data_i = 8'h00;

      // Reset
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("rst_empty", 32'(empty_o), 32'd1);
      check("rst_ot", 32'(ot()), 32'b000);
      check("rst_data", 32'(data_o), 32'h00);

      // Single transfer
      wr(8'hAA);
      check("one_ot", 32'(ot()), 32'b100);
      check("one_empty", 32'(empty_o), 32'd0);
      rd();
      check("one_data", 32'(data_o), 32'hAA);
      check("one_empty2", 32'(empty_o), 32'd1);

      // Read while empty is ignored, data_o holds
      rd();
      check("empty_rd_hold", 32'(data_o), 32'hAA);
`ifdef FIFO_ERR_FLAG_EN
      check("err_empty", 32'(err_o), 32'd1);
      rd();
      wr(8'h01);
      check("err_clear", 32'(err_o), 32'd0);
      rd();
      check("err_rd", 32'(data_o), 32'h01);
`endif

      // Fill and overflow
      wr(8'h70);
      check("fill0", 32'(ot()), 32'b100);
      wr(8'h71);
      check("fill1", 32'(ot()), 32'b110);
      wr(8'h72);
      check("fill2", 32'(ot()), 32'b110);
      wr(8'h73);
      check("fill3", 32'(ot()), 32'b111);
      wr(8'hAB);
      check("ovf_ot", 32'(ot()), 32'b111);
`ifdef FIFO_ERR_FLAG_EN
      check("err_full", 32'(err_o), 32'd1);
`endif
      for (int i = 0; i < 4; i++) begin
         rd();
         check("drain", 32'(data_o), 32'(8'h70 + i));
      end
      check("drain_empty", 32'(empty_o), 32'd1);

      // Read+write on empty: read dropped, write stored
      step(1'b0, 1'b1, 8'h80, 1'b1);
      check("rw_empty_hold", 32'(data_o), 32'h73);
      check("rw_empty_ot", 32'(ot()), 32'b100);
      rd();
      check("rw_empty_rd", 32'(data_o), 32'h80);
      check("rw_empty_e", 32'(empty_o), 32'd1);

      // Read+write with one entry
      wr(8'h90);
      step(1'b0, 1'b1, 8'hA0, 1'b1);
      check("rw_one_data", 32'(data_o), 32'h90);
      check("rw_one_ot", 32'(ot()), 32'b100);
      rd();
      check("rw_one_rd", 32'(data_o), 32'hA0);
      check("rw_one_e", 32'(empty_o), 32'd1);

      // Read+write on full, across pointer wrap
      for (int i = 0; i < 4; i++) wr(8'(8'h10 + i));
      check("rw_full_pre", 32'(ot()), 32'b111);
      step(1'b0, 1'b1, 8'h20, 1'b1);
      check("rw_full_data", 32'(data_o), 32'h10);
      check("rw_full_ot", 32'(ot()), 32'b110);
      step(1'b0, 1'b1, 8'h21, 1'b1);
      check("rw_full_d2", 32'(data_o), 32'h11);
      check("rw_full_ot2", 32'(ot()), 32'b110);
      rd();
      check("rw_full_r0", 32'(data_o), 32'h12);
      rd();
      check("rw_full_r1", 32'(data_o), 32'h13);
      check("rw_full_ot3", 32'(ot()), 32'b100);
      rd();
      check("rw_full_r2", 32'(data_o), 32'h21);
      check("rw_full_e", 32'(empty_o), 32'd1);

      // Reset mid-operation wins over a write and discards entries
      wr(8'h55);
      wr(8'h66);
      step(1'b1, 1'b1, 8'h77, 1'b1);
      check("midrst_empty", 32'(empty_o), 32'd1);
      check("midrst_ot", 32'(ot()), 32'b000);
      check("midrst_data", 32'(data_o), 32'h00);
      wr(8'h5A);
      rd();
      check("post_rst_rd", 32'(data_o), 32'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
